// File: rtl/neuron_accumulator.sv
// neuron_accumulator
//   Forms one neuron's pre-activation sum: bias plus N_INPUTS products of
//   unsigned activations and signed weights, saturated to ACC_W-bit signed.
//   Feeds the sigmoid stage; ovf flags that clamping happened at least once.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, bias     begin a neuron (sampled in IDLE only), initial acc value
//   in_valid/ready  activation/weight beat handshake (in_data, in_weight)
//   sum_out, ovf    saturated sum and sticky saturation flag
//   out_valid/ready result handshake
//   busy            high whenever not IDLE
module neuron_accumulator #(
  parameter int N_INPUTS = 16,
  parameter int DW       = 8,
  parameter int WW       = 8,
  parameter int ACC_W    = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    in_valid,
  input  logic        [DW-1:0]    in_data,
  input  logic signed [WW-1:0]    in_weight,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] sum_out,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int PW    = DW + WW + 1;
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0]        N_CNT   = CNT_W'(N_INPUTS);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_p1;
  logic                      vld_p1;
  logic signed [PW-1:0]      prod_p1;
  logic signed [PW-1:0]      prod_d;
  logic signed [ACC_W-1:0]   acc_p2;
  logic                      ovf_p2;
  logic signed [ACC_W:0]     sum_x;
  logic                      beat;

  // The sum is one bit wider than the accumulator, so it cannot wrap.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi = {ACC_MAX[ACC_W-1], ACC_MAX};
    lo = {ACC_MIN[ACC_W-1], ACC_MIN};
    if (s > hi)      sat_acc = ACC_MAX;
    else if (s < lo) sat_acc = ACC_MIN;
    else             sat_acc = s[ACC_W-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [ACC_W:0] s);
    is_sat = (s[ACC_W] != s[ACC_W-1]);
  endfunction

  assign in_ready  = (state_q == ACCUM) && (cnt_p1 < N_CNT);
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = acc_p2;
  assign ovf       = ovf_p2;

  // Activation is zero-extended so it multiplies as a non-negative value.
  assign prod_d = $signed({1'b0, in_data}) * $signed(in_weight);
  assign sum_x  = $signed({acc_p2[ACC_W-1], acc_p2})
                + $signed({{(ACC_W+1-PW){prod_p1[PW-1]}}, prod_p1});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      // Leave only after the last product has been folded into acc.
      ACCUM:   if ((cnt_p1 == N_CNT) && !vld_p1) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: product register (data only, qualified by vld_p1)
  always_ff @(posedge clk) begin
    if (beat) prod_p1 <= prod_d;
  end

  // Stage 2: accumulate with per-addition saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_p1  <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_p2  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (start) begin
          acc_p2 <= bias;
          cnt_p1 <= '0;
          ovf_p2 <= 1'b0;
          vld_p1 <= 1'b0;
        end
      end else if (state_q == ACCUM) begin
        vld_p1 <= beat;
        if (beat) cnt_p1 <= cnt_p1 + 1'b1;
        if (vld_p1) begin
          acc_p2 <= sat_acc(sum_x);
          if (is_sat(sum_x)) ovf_p2 <= 1'b1;
        end
      end
    end
  end

endmodule
